booth_mult_pipe: RTL and testbench



---
 rtl/mult_pkg.sv | 23 ++
 rtl/booth_pp_gen.sv | 32 +++
 rtl/booth_mult_pipe.sv | 100 ++++++++++
 tb/tb_booth_mult_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier core.
package mult_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

  localparam int STAGES = 3;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: booth_decode = POS1;
      3'b011:         booth_decode = POS2;
      3'b100:         booth_decode = NEG2;
      3'b101, 3'b110: booth_decode = NEG1;
      default:        booth_decode = ZERO;
    endcase
  endfunction

  function automatic int num_pp(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth partial product: digit(triplet) * A_ext, sign-extended to 2*WIDTH
// and aligned to digit position IDX.
module booth_pp_gen
  import mult_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int IDX   = 0
) (
  input  logic [2:0]         triplet_i,
  input  logic [WIDTH+1:0]   a_ext_i,
  output logic [2*WIDTH-1:0] pp_o
);

  logic [2*WIDTH-1:0] w_a1, w_a2, w_mag;

  assign w_a1 = {{(WIDTH-2){a_ext_i[WIDTH+1]}}, a_ext_i};
  assign w_a2 = w_a1 << 1;

  always_comb begin
    w_mag = '0;
    case (booth_decode(triplet_i))
      POS1:    w_mag = w_a1;
      POS2:    w_mag = w_a2;
      NEG1:    w_mag = -w_a1;
      NEG2:    w_mag = -w_a2;
      default: w_mag = '0;
    endcase
  end

  assign pp_o = w_mag << (2 * IDX);

endmodule

// File: rtl/booth_mult_pipe.sv
// Three-stage radix-4 Booth multiplier (encode / CSA reduce / CPA) with
// per-op signed mode, tag sideband and a global-stall valid/ready handshake.
module booth_mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic [TAG_W-1:0]   tag_o
);

  localparam int NUM_PP = num_pp(WIDTH);
  localparam int PW     = 2 * WIDTH;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_pipe: WIDTH must be even and >= 4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("booth_mult_pipe: TAG_W must be >= 1");
  end

  logic              w_adv;
  logic [STAGES:1]   r_vld_pipe;

  // Whole pipe moves together; bubbles are not squeezed out.
  assign w_adv   = ~r_vld_pipe[STAGES] | ready_i;
  assign ready_o = w_adv;
  assign valid_o = r_vld_pipe[STAGES];

  // S1: extend operands, pad multiplier with an implicit 0 below LSB
  logic [WIDTH+1:0] w_a_ext;
  logic [WIDTH+2:0] w_b_pad;

  assign w_a_ext = {{2{signed_i & a_i[WIDTH-1]}}, a_i};
  assign w_b_pad = {{2{signed_i & b_i[WIDTH-1]}}, b_i, 1'b0};

  logic [NUM_PP-1:0][PW-1:0] w_pp, r_pp;
  logic [TAG_W-1:0]          r_tag1, r_tag2, r_tag3;

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen #(.WIDTH(WIDTH), .IDX(i)) u_pp (
      .triplet_i (w_b_pad[2*i+2:2*i]),
      .a_ext_i   (w_a_ext),
      .pp_o      (w_pp[i])
    );
  end

  // S2: linear chain of 3:2 compressors, one partial product folded per level
  for (genvar i = 0; i < NUM_PP; i++) begin : g_csa
    logic [PW-1:0] w_s, w_c;
    if (i == 0) begin : g_init
      assign w_s = r_pp[0];
      assign w_c = '0;
    end else begin : g_step
      assign w_s = g_csa[i-1].w_s ^ g_csa[i-1].w_c ^ r_pp[i];
      assign w_c = ((g_csa[i-1].w_s & g_csa[i-1].w_c) |
                    (g_csa[i-1].w_s & r_pp[i])        |
                    (g_csa[i-1].w_c & r_pp[i])) << 1;
    end
  end

  logic [PW-1:0] r_sum, r_cry, r_prod;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vld_pipe <= '0;
      r_pp       <= '0;
      r_tag1     <= '0;
      r_sum      <= '0;
      r_cry      <= '0;
      r_tag2     <= '0;
      r_prod     <= '0;
      r_tag3     <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], valid_i};
      r_pp       <= w_pp;
      r_tag1     <= tag_i;
      r_sum      <= g_csa[NUM_PP-1].w_s;
      r_cry      <= g_csa[NUM_PP-1].w_c;
      r_tag2     <= r_tag1;
      r_prod     <= r_sum + r_cry;
      r_tag3     <= r_tag2;
    end
  end

  assign product_o = r_prod;
  assign tag_o     = r_tag3;

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Directed-vector bench for booth_mult_pipe (WIDTH=24): table stream,
// latency, backpressure, mid-flight reset, plus a short randomised run.
module tb_booth_mult_pipe;

  localparam int W  = 24;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rstn_i, valid_i, ready_o, signed_i, valid_o, ready_i;
  logic [W-1:0]    a_i, b_i;
  logic [TW-1:0]   tag_i, tag_o;
  logic [2*W-1:0]  product_o;

  booth_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .signed_i(signed_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .product_o(product_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sgn;
    logic [W-1:0]  a, b;
    logic [TW-1:0] tag;
    logic [2*W-1:0] exp;
  } vec_t;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [TW-1:0]  t;
  } exp_t;

  vec_t           vecs[12];
  exp_t           exp_q[$];
  logic [2*W-1:0] drv_exp;
  int             n_cmp = 0;
  int             n_err = 0;
  int             cyc = 0;
  bit             rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Scoreboard: transfers are decided by levels that are stable at negedge.
  always @(negedge clk) begin
    if (!rstn_i) exp_q.delete();
    else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_out", {16'd0, product_o}, 64'hDEAD);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", {16'd0, product_o}, {16'd0, e.p});
          chk("tag", {60'd0, tag_o}, {60'd0, e.t});
        end
      end
      if (valid_i && ready_o) exp_q.push_back({drv_exp, tag_i});
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t, input logic [2*W-1:0] e);
    bit ok;
    ok = 0;
    signed_i = s; a_i = a; b_i = b; tag_i = t; drv_exp = e; valid_i = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (ready_o) ok = 1;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    chk(nm, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    logic [2*W-1:0] p_hold;
    logic [TW-1:0]  t_hold;
    bit seen;

    vecs[0]  = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 4'd1,  48'hFFFFFE000001};
    vecs[1]  = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 4'd2,  48'h000000000001};
    vecs[2]  = '{1'b1, 24'h800000, 24'h800000, 4'd3,  48'h400000000000};
    vecs[3]  = '{1'b1, 24'hFFFFFF, 24'h000001, 4'd4,  48'hFFFFFFFFFFFF};
    vecs[4]  = '{1'b0, 24'h000000, 24'h123456, 4'd5,  48'h000000000000};
    vecs[5]  = '{1'b0, 24'h000002, 24'h000003, 4'd6,  48'h000000000006};
    vecs[6]  = '{1'b1, 24'h7FFFFF, 24'h7FFFFF, 4'd7,  48'h3FFFFF000001};
    vecs[7]  = '{1'b1, 24'h800000, 24'h7FFFFF, 4'd8,  48'hC00000800000};
    vecs[8]  = '{1'b0, 24'h800000, 24'h000002, 4'd9,  48'h000001000000};
    vecs[9]  = '{1'b1, 24'hFFFFFE, 24'h000003, 4'd10, 48'hFFFFFFFFFFFA};
    vecs[10] = '{1'b0, 24'h123456, 24'h000010, 4'd11, 48'h000001234560};
    vecs[11] = '{1'b1, 24'h000005, 24'hFFFFFD, 4'd12, 48'hFFFFFFFFFFF1};

    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; signed_i = 1'b0;
    a_i = '0; b_i = '0; tag_i = '0; drv_exp = '0;

    // Reset state
    #12;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_product_o", {16'd0, product_o}, 0);
    chk("rst_tag_o", tag_o, 0);
    chk("rst_ready_o", ready_o, 1);
    @(posedge clk); #1; rstn_i = 1'b1;
    @(posedge clk); #1;

    // Latency: offered after edge n, visible after edge n+3
    signed_i = 1'b0; a_i = 24'h000007; b_i = 24'h000009; tag_i = 4'hA;
    drv_exp = 48'd63; valid_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    @(negedge clk); chk("lat_s1", valid_o, 0);
    @(negedge clk); chk("lat_s2", valid_o, 0);
    @(negedge clk); chk("lat_s3", valid_o, 1);
    drain("lat_drain");

    // Table stream: back-to-back mixed modes, one accept per cycle
    c0 = cyc;
    foreach (vecs[i]) send(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);
    chk("stream_cycles", cyc - c0, 12);
    drain("stream_drain");

    // Backpressure: 4 ops offered into a stalled pipe
    ready_i = 1'b0;
    fork
      begin
        send(1'b0, 24'h000003, 24'h000005, 4'd1, 48'h00000000000F);
        send(1'b1, 24'hFFFFFF, 24'h000002, 4'd2, 48'hFFFFFFFFFFFE);
        send(1'b0, 24'hFFFFFF, 24'h000002, 4'd3, 48'h000001FFFFFE);
        send(1'b1, 24'h400000, 24'h000004, 4'd4, 48'h000001000000);
      end
      begin
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          if (valid_o) seen = 1;
        end
        chk("bp_fill", seen, 1);
        p_hold = product_o; t_hold = tag_o;
        chk("bp_first", {16'd0, p_hold}, 64'hF);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_ready_low", ready_o, 0);
          chk("bp_prod_hold", {16'd0, product_o}, {16'd0, p_hold});
          chk("bp_tag_hold", tag_o, t_hold);
        end
        @(posedge clk); #1; ready_i = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with 3 ops in flight
    send(1'b0, 24'h000011, 24'h000011, 4'd5, 48'h000000000121);
    send(1'b1, 24'hFFFFF0, 24'h000010, 4'd6, 48'hFFFFFFFFFF00);
    send(1'b0, 24'h000100, 24'h000100, 4'd7, 48'h000000010000);
    chk("rst_inflight", valid_o, 1);
    #1 rstn_i = 1'b0;
    #1 chk("rst_async_valid", valid_o, 0);
    chk("rst_async_ready", ready_o, 1);
    @(posedge clk); #1; rstn_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rst_no_stale", valid_o, 0);
    end
    @(posedge clk); #1;
    send(1'b1, 24'h800000, 24'hFFFFFF, 4'd9, 48'h000000800000);
    drain("post_rst_drain");

    // Randomised ops with random backpressure
    rnd_done = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic s;
          logic [W-1:0] a, b;
          s = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 4))
            0: a = 24'h800000; 1: a = 24'hFFFFFF; 2: a = 24'h7FFFFF;
            default: a = 24'($urandom);
          endcase
          b = ($urandom_range(0, 4) == 0) ? 24'h800000 : 24'($urandom);
          send(s, a, b, 4'($urandom), model(s, a, b));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1; ready_i = 1'b1;
    drain("rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
